alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width and number of slice steps.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel an operation in RUN.
REQ-006 SHALL have port src1, src2  input  WIDTH  operands, captured on the accepting edge.
REQ-007 SHALL have port ALU_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-008 SHALL have port slice_src1, slice_src2, slice_cin, slice_less  output  1 each  bit drive to the 1-bit slice.
REQ-009 SHALL have port slice_A_invert, slice_B_invert  output  1 each  inversion flags to the slice.
REQ-010 SHALL have port slice_operation  output  3  000 AND, 001 OR, 010 ADD.
REQ-011 SHALL have port slice_result, slice_cout  input  1 each  combinational slice response.
REQ-012 SHALL have ports busy, done, err  output  1 each  status.
REQ-013 SHALL have ports result  output  WIDTH; zero, cout, overflow  output  1 each.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; a 5-bit step counter bit_idx; a carry register c.
REQ-015 IDLE & start & valid code: capture operands and code, bit_idx<=0, c<=1 for SUB/SLT else 0, -> RUN, busy=1.
REQ-016 IDLE & start & invalid code: -> DONE next edge, err=1, result=0, zero=1, cout=0, overflow=0.
REQ-017 In RUN, slice drive SHALL be: slice_src1=A[bit_idx]^Ainv, slice_src2=B[bit_idx]^Binv, slice_cin=c, slice_less=0, flags equal to Ainv/Binv.
REQ-018 Per code: AND op=000 Ainv=Binv=0; OR op=001; ADD op=010; SUB/SLT op=010 Binv=1; NOR op=000 Ainv=Binv=1.
REQ-019 Each RUN edge: result[bit_idx]<=slice_result, c<=slice_cout, bit_idx<=bit_idx+1.
REQ-020 On the RUN edge with bit_idx=WIDTH-1: record carry-in c as c_msb, -> DONE.
REQ-021 Outputs SHALL be combinational from the slice only via the registered operands/state (no input-to-output paths except slice_result/slice_cout -> register).
REQ-022 In DONE, for one cycle: done=1, busy=0; next edge -> IDLE.
REQ-023 DONE results: cout=c (final carry) for ADD/SUB/SLT else 0; overflow=c_msb^c for ADD/SUB/SLT else 0.
REQ-024 SLT: result={WIDTH-1 zeros, set}, set=sum[WIDTH-1]^overflow; cout, overflow as SUB.
REQ-025 zero SHALL equal (result==0), registered with result.
REQ-026 result/zero/cout/overflow/err SHALL hold from DONE until the next accepted start.
REQ-027 start in RUN or DONE SHALL be ignored (not queued).
REQ-028 abort in RUN: -> IDLE next edge, no done, busy=0; result/zero/cout/overflow/err keep prior completed values (partial work discarded via shadow register).
REQ-029 abort and final-bit edge simultaneous: abort wins.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 Latency: accepting edge to done=1 SHALL be exactly WIDTH+1 cycles for valid codes, 1 cycle for invalid.
REQ-032 Slice outputs in IDLE/DONE SHALL be all zero.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, bit_idx=0, c=0, busy=0, done=0, err=0, result=0, zero=1, cout=0, overflow=0, all slice outputs 0.
REQ-034 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first start after release accepted normally.

Verification
REQ-035 ADD 0x7FFFFFFF+0x00000001 -> done at cycle 33, result 0x80000000, overflow=1, cout=0, zero=0.
REQ-036 SUB 5-5 -> result 0, zero=1, cout=1, overflow=0; SLT 0x80000000 vs 1 -> result 1.
REQ-037 NOR 0x0F0F0F0F,0x00FF00FF -> result 0xF000F000; slice flags Ainv=Binv=1, op=000 every RUN cycle.
REQ-038 abort at bit 10 of ADD after prior result 0x12345678 -> IDLE, no done, result stays 0x12345678.
REQ-039 invalid code 1111 -> done one cycle after start, err=1, result 0; start pulses during RUN ignored.
REQ-040 rst_n low at bit 20 -> all outputs reset values immediately, no done; next ADD 3+4 -> result 7.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer that drives an external 1-bit ALU
// slice one bit per clock. It assembles a WIDTH-bit result, carry and
// overflow, and presents them with a one-cycle done pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; the slice interface is held at zero
// RUN   | one slice step per edge, walking bit_idx from 0 to WIDTH-1
// DONE  | single-cycle done pulse; the next edge returns to IDLE
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             slice_src1,
    output logic             slice_src2,
    output logic             slice_cin,
    output logic             slice_less,
    output logic             slice_A_invert,
    output logic             slice_B_invert,
    output logic [2:0]       slice_operation,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;
    localparam logic [3:0] CODE_SLT = 4'b0111;
    localparam logic [3:0] CODE_NOR = 4'b1100;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    bit_idx;
    logic             c;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             ainv_q;
    logic             binv_q;
    logic             arith_q;
    logic             slt_q;
    // Partial result of the operation in flight. It is kept apart from
    // `result` so that an abort leaves the last completed answer visible.
    logic [WIDTH-1:0] work_q;

    logic             dec_valid;
    logic [2:0]       dec_op;
    logic             dec_ainv;
    logic             dec_binv;
    logic             dec_cin;
    logic             dec_arith;
    logic             dec_slt;

    logic [WIDTH-1:0] work_next;
    logic             ovf_fin;
    logic [WIDTH-1:0] final_word;

    // Decode the operation code presented at the accepting edge.
    always_comb begin
        dec_valid = 1'b1;
        dec_op    = OP_AND;
        dec_ainv  = 1'b0;
        dec_binv  = 1'b0;
        dec_cin   = 1'b0;
        dec_arith = 1'b0;
        dec_slt   = 1'b0;
        case (ALU_control)
            CODE_AND: dec_op = OP_AND;
            CODE_OR:  dec_op = OP_OR;
            CODE_ADD: begin
                dec_op    = OP_ADD;
                dec_arith = 1'b1;
            end
            CODE_SUB: begin
                dec_op    = OP_ADD;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_arith = 1'b1;
            end
            CODE_SLT: begin
                dec_op    = OP_ADD;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_arith = 1'b1;
                dec_slt   = 1'b1;
            end
            CODE_NOR: begin
                dec_op   = OP_AND;
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Merge the current slice bit into the partial word. On the last step
    // the carry-in still held in c is the carry into the MSB, so
    // overflow is that carry XOR the carry out of the MSB.
    always_comb begin
        work_next          = work_q;
        work_next[bit_idx] = slice_result;
        ovf_fin            = c ^ slice_cout;
        if (slt_q) begin
            final_word = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_fin};
        end else begin
            final_word = work_next;
        end
    end

    // Slice drive comes only from registered operands and state. It is
    // forced to zero whenever no step is in progress.
    always_comb begin
        slice_src1      = 1'b0;
        slice_src2      = 1'b0;
        slice_cin       = 1'b0;
        slice_less      = 1'b0;
        slice_A_invert  = 1'b0;
        slice_B_invert  = 1'b0;
        slice_operation = 3'b000;
        if (state == S_RUN) begin
            slice_src1      = a_q[bit_idx] ^ ainv_q;
            slice_src2      = b_q[bit_idx] ^ binv_q;
            slice_cin       = c;
            slice_A_invert  = ainv_q;
            slice_B_invert  = binv_q;
            slice_operation = op_q;
        end
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_idx  <= '0;
            c        <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            ainv_q   <= 1'b0;
            binv_q   <= 1'b0;
            arith_q  <= 1'b0;
            slt_q    <= 1'b0;
            work_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dec_valid) begin
                            a_q     <= src1;
                            b_q     <= src2;
                            op_q    <= dec_op;
                            ainv_q  <= dec_ainv;
                            binv_q  <= dec_binv;
                            arith_q <= dec_arith;
                            slt_q   <= dec_slt;
                            c       <= dec_cin;
                            bit_idx <= '0;
                            work_q  <= '0;
                            busy    <= 1'b1;
                            state   <= S_RUN;
                        end else begin
                            err      <= 1'b1;
                            result   <= '0;
                            zero     <= 1'b1;
                            cout     <= 1'b0;
                            overflow <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Partial work is dropped; the published result is untouched.
                        bit_idx <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        work_q  <= work_next;
                        c       <= slice_cout;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx  <= '0;
                            result   <= final_word;
                            zero     <= (final_word == '0);
                            cout     <= arith_q ? slice_cout : 1'b0;
                            overflow <= arith_q ? ovf_fin : 1'b0;
                            err      <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: models the 1-bit slice combinationally and
// checks each operation against word-level arithmetic.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         slice_src1;
    logic         slice_src2;
    logic         slice_cin;
    logic         slice_less;
    logic         slice_A_invert;
    logic         slice_B_invert;
    logic [2:0]   slice_operation;
    logic         slice_result;
    logic         slice_cout;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_result;
    logic         exp_zero;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_err;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .src1            (src1),
        .src2            (src2),
        .ALU_control     (ALU_control),
        .slice_src1      (slice_src1),
        .slice_src2      (slice_src2),
        .slice_cin       (slice_cin),
        .slice_less      (slice_less),
        .slice_A_invert  (slice_A_invert),
        .slice_B_invert  (slice_B_invert),
        .slice_operation (slice_operation),
        .slice_result    (slice_result),
        .slice_cout      (slice_cout),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .result          (result),
        .zero            (zero),
        .cout            (cout),
        .overflow        (overflow)
    );

    // 1-bit ALU slice model
    assign slice_result = (slice_operation == 3'b000) ? (slice_src1 & slice_src2) :
                          (slice_operation == 3'b001) ? (slice_src1 | slice_src2) :
                          (slice_operation == 3'b010) ? (slice_src1 ^ slice_src2 ^ slice_cin) :
                          slice_less;
    assign slice_cout = (slice_src1 & slice_src2) | (slice_src1 & slice_cin) |
                        (slice_src2 & slice_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] slice_bus();
        return {slice_src1, slice_src2, slice_cin, slice_less,
                slice_A_invert, slice_B_invert, slice_operation};
    endfunction

    // Expected slice controls per operation code
    task automatic expect_ctl(input logic [3:0] code, output logic [2:0] op,
                              output logic ainv, output logic binv, output logic cin);
        op = 3'b000; ainv = 1'b0; binv = 1'b0; cin = 1'b0;
        case (code)
            4'b0001: op = 3'b001;
            4'b0010: op = 3'b010;
            4'b0110, 4'b0111: begin op = 3'b010; binv = 1'b1; cin = 1'b1; end
            4'b1100: begin ainv = 1'b1; binv = 1'b1; end
            default: ;
        endcase
    endtask

    // Word-level reference
    task automatic model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic co, output logic ov, output logic er);
        logic [W:0] s;
        r = '0; co = 1'b0; ov = 1'b0; er = 1'b0;
        case (code)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110, 4'b0111: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                if (code == 4'b0111) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            default: er = 1'b1;
        endcase
    endtask

    // abort_k: bit step to abort at (-1 none, -2 abort asserted in IDLE with start)
    // stray_k: bit step at which a stray start is pulsed during RUN (-1 none)
    // done_start: pulse start while in DONE
    task automatic run_op(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int abort_k, input int stray_k,
                          input bit done_start);
        logic [W-1:0] er;
        logic eco, eov, eerr, eainv, ebinv, ecin;
        logic [2:0] eop;
        int cyc, bad, k;
        bit aborted;
        model(code, a, b, er, eco, eov, eerr);
        expect_ctl(code, eop, eainv, ebinv, ecin);
        @(negedge clk);
        start = 1'b1; src1 = a; src2 = b; ALU_control = code;
        if (abort_k == -2) abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
        cyc = 1; bad = 0; aborted = 1'b0;
        while (!done && cyc < 2*W + 8) begin
            k = cyc - 1;
            if (busy && k < W) begin
                if (slice_A_invert !== eainv) bad++;
                if (slice_B_invert !== ebinv) bad++;
                if (slice_operation !== eop) bad++;
                if (slice_less !== 1'b0) bad++;
                if (slice_src1 !== (a[k] ^ eainv)) bad++;
                if (slice_src2 !== (b[k] ^ ebinv)) bad++;
                if (k == 0 && slice_cin !== ecin) bad++;
            end
            if (k == abort_k) abort = 1'b1;
            if (k == stray_k) start = 1'b1;
            @(negedge clk);
            cyc++;
            abort = 1'b0; start = 1'b0;
            if (abort_k >= 0 && k == abort_k) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            chk({tag, " abort busy"}, busy, 0);
            chk({tag, " abort done"}, done, 0);
            chk({tag, " abort result"}, result, exp_result);
            chk({tag, " abort zero"}, zero, exp_zero);
            chk({tag, " abort err"}, err, exp_err);
            chk({tag, " abort cout/ovf"}, {cout, overflow}, {exp_cout, exp_ovf});
            chk({tag, " abort slice idle"}, slice_bus(), 0);
            @(negedge clk);
            chk({tag, " abort no done"}, {busy, done}, 0);
        end else begin
            chk({tag, " done"}, done, 1);
            chk({tag, " latency"}, cyc, eerr ? 1 : W + 1);
            chk({tag, " slice flags"}, bad, 0);
            chk({tag, " result"}, result, er);
            chk({tag, " zero"}, zero, (er == '0));
            chk({tag, " cout"}, cout, eco);
            chk({tag, " overflow"}, overflow, eov);
            chk({tag, " err"}, err, eerr);
            chk({tag, " busy in done"}, busy, 0);
            chk({tag, " slice in done"}, slice_bus(), 0);
            exp_result = er; exp_zero = (er == '0); exp_cout = eco;
            exp_ovf = eov; exp_err = eerr;
            if (done_start) begin
                start = 1'b1; ALU_control = 4'b0010;
                @(negedge clk);
                start = 1'b0;
                chk({tag, " start in done ignored"}, {busy, done}, 0);
                @(negedge clk);
                chk({tag, " start in done not queued"}, busy, 0);
            end else begin
                @(negedge clk);
                chk({tag, " done one cycle"}, done, 0);
            end
        end
    endtask

    initial begin
        logic [3:0] codes [7];
        logic [3:0] code;
        logic [W-1:0] a, b;
        int ak;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0;
        exp_result = '0; exp_zero = 1'b1; exp_cout = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset status", {busy, done, err}, 0);
        chk("reset result", result, 0);
        chk("reset flags", {zero, cout, overflow}, 3'b100);
        chk("reset slice", slice_bus(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle slice", slice_bus(), 0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, -1, -1, 1'b0);
        run_op("sub_eq", 4'b0110, 32'd5, 32'd5, -1, -1, 1'b0);
        run_op("slt_neg", 4'b0111, 32'h8000_0000, 32'd1, -1, -1, 1'b0);
        run_op("nor", 4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, -1, -1, 1'b0);
        run_op("add_prior", 4'b0010, 32'h1234_5000, 32'h0000_0678, -1, -1, 1'b0);
        run_op("add_abort10", 4'b0010, 32'hFFFF_0000, 32'h0001_0000, 10, -1, 1'b0);
        run_op("sub_abort_last", 4'b0110, 32'd9, 32'd4, W - 1, -1, 1'b0);
        run_op("invalid", 4'b1111, 32'hDEAD_BEEF, 32'h1, -1, -1, 1'b0);
        run_op("and_stray", 4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, -1, 7, 1'b0);
        run_op("or_done_start", 4'b0001, 32'hA000_0005, 32'h0500_000A, -1, -1, 1'b1);
        run_op("idle_abort", 4'b0010, 32'h0000_FFFF, 32'hFFFF_0001, -2, -1, 1'b0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; src1 = 32'h1111_1111; src2 = 32'h2222_2222; ALU_control = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset status", {busy, done, err}, 0);
        chk("midrun reset result", result, 0);
        chk("midrun reset flags", {zero, cout, overflow}, 3'b100);
        chk("midrun reset slice", slice_bus(), 0);
        exp_result = '0; exp_zero = 1'b1; exp_cout = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun reset no done", done, 0);
        rst_n = 1'b1;
        run_op("add_after_reset", 4'b0010, 32'd3, 32'd4, -1, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            code = codes[$urandom_range(0, 6)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            ak = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_op($sformatf("rand%0d", i), code, a, b, ak, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
